// File: rtl/pci_pkg.sv
// -----------------------------------------------------------------------------
// pci_pkg
// Shared definitions for the PCI bus arbiter and the PCI test masters.
//   arb_state_t   : arbiter FSM state encoding (PARK / GRANT / GAP)
//   CMD_*         : PCI C/BE# command encodings used during the address phase
//   bus_is_idle() : bus idle qualifier (FRAME# and IRDY# both deasserted)
// -----------------------------------------------------------------------------
package pci_pkg;

    typedef enum logic [1:0] {
        ST_PARK  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } arb_state_t;

    localparam logic [3:0] CMD_INT_ACK        = 4'b0000;
    localparam logic [3:0] CMD_SPECIAL        = 4'b0001;
    localparam logic [3:0] CMD_IO_READ        = 4'b0010;
    localparam logic [3:0] CMD_IO_WRITE       = 4'b0011;
    localparam logic [3:0] CMD_MEM_READ       = 4'b0110;
    localparam logic [3:0] CMD_MEM_WRITE      = 4'b0111;
    localparam logic [3:0] CMD_CFG_READ       = 4'b1010;
    localparam logic [3:0] CMD_CFG_WRITE      = 4'b1011;
    localparam logic [3:0] CMD_MEM_READ_MULT  = 4'b1100;
    localparam logic [3:0] CMD_DUAL_ADDR      = 4'b1101;
    localparam logic [3:0] CMD_MEM_READ_LINE  = 4'b1110;
    localparam logic [3:0] CMD_MEM_WRITE_INV  = 4'b1111;

    function automatic logic bus_is_idle(input logic frame_n, input logic irdy_n);
        return frame_n & irdy_n;
    endfunction

endpackage

// File: rtl/pci_rr_pick.sv
// -----------------------------------------------------------------------------
// pci_rr_pick
// Combinational rotate-priority picker. The master just after last_owner has
// the highest priority, last_owner itself the lowest.
//   req        in  N_REQ        active-high request vector
//   last_owner in  clog2(N_REQ) most recent grant holder
//   winner     out clog2(N_REQ) selected master (only meaningful if any_req)
//   any_req    out 1            at least one request pending
// -----------------------------------------------------------------------------
module pci_rr_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] last_owner,
    output logic [$clog2(N_REQ)-1:0] winner,
    output logic                     any_req
);

    localparam int ID_W = $clog2(N_REQ);

    logic [ID_W-1:0] idx;

    // Walk from lowest to highest priority so the last hit is the winner.
    always_comb begin
        winner = last_owner;
        idx    = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = ID_W'((int'(last_owner) + k) % N_REQ);
            if (req[idx]) begin
                winner = idx;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/pci_arbiter.sv
// -----------------------------------------------------------------------------
// pci_arbiter
// Central PCI bus arbiter: round-robin with bus parking, one transaction per
// grant under contention, and revocation of grants left unused on an idle bus.
//   PCLK        in  1             bus clock, rising edge
//   RST_N       in  1             asynchronous active-low reset
//   REQ_N       in  N_REQ         per-master request, active low
//   GNT_N       out N_REQ         per-master grant, active low, registered
//   FRAME_N     in  1             bus FRAME#, sampled only
//   IRDY_N      in  1             bus IRDY#, sampled only
//   grant_id    out clog2(N_REQ)  current grant holder, registered
//   grant_valid out 1             a grant is asserted, registered
//   timeout_evt out 1             one-cycle pulse when a grant times out
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_PARK  | no requests; PARK master holds the bus grant
// ST_GRANT | grant_id owns the grant and has an active request
// ST_GAP   | one cycle with every grant deasserted, then arbitrate
// -----------------------------------------------------------------------------
module pci_arbiter
    import pci_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int PARK    = 0,
    parameter int TIMEOUT = 16
) (
    input  logic                     PCLK,
    input  logic                     RST_N,
    input  logic [N_REQ-1:0]         REQ_N,
    output logic [N_REQ-1:0]         GNT_N,
    input  logic                     FRAME_N,
    input  logic                     IRDY_N,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     grant_valid,
    output logic                     timeout_evt
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [ID_W-1:0]  PARK_ID   = ID_W'(PARK);
    localparam logic [ID_W-1:0]  LAST_RST  = ID_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(TIMEOUT);
    localparam logic [N_REQ-1:0] PARK_MASK = N_REQ'(1) << PARK;

    arb_state_t       state;
    logic [ID_W-1:0]  last_owner;
    logic [ID_W-1:0]  winner;
    logic [CNT_W-1:0] idle_cnt;
    logic [CNT_W-1:0] idle_cnt_nxt;
    logic             started;
    logic             any_req;
    logic             bus_idle;
    logic             owner_req;
    logic             other_req;
    logic             park_other;
    logic             revoke;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] owner_mask;

    assign req        = ~REQ_N;
    assign bus_idle   = bus_is_idle(FRAME_N, IRDY_N);
    assign owner_mask = N_REQ'(1) << grant_id;
    assign owner_req  = |(req & owner_mask);
    assign other_req  = |(req & ~owner_mask);
    assign park_other = |(req & ~PARK_MASK);

    // The current bus owner is never waited for: dropping the grant only
    // stops the owner from starting another transaction.
    assign revoke = !owner_req || (started && other_req) || (idle_cnt == CNT_MAX);

    // Counts idle clocks of an unused grant; any bus activity restarts it.
    always_comb begin
        idle_cnt_nxt = idle_cnt;
        if (!bus_idle) begin
            idle_cnt_nxt = '0;
        end else if (!started && (idle_cnt != CNT_MAX)) begin
            idle_cnt_nxt = idle_cnt + CNT_W'(1);
        end
    end

    pci_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req        (req),
        .last_owner (last_owner),
        .winner     (winner),
        .any_req    (any_req)
    );

    always_ff @(posedge PCLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= ST_GAP;
            GNT_N       <= '1;
            grant_id    <= '0;
            grant_valid <= 1'b0;
            timeout_evt <= 1'b0;
            last_owner  <= LAST_RST;
            idle_cnt    <= '0;
            started     <= 1'b0;
        end else begin
            timeout_evt <= 1'b0;
            case (state)
                ST_GAP: begin
                    idle_cnt <= '0;
                    started  <= 1'b0;
                    if (any_req) begin
                        state       <= ST_GRANT;
                        GNT_N       <= ~(N_REQ'(1) << winner);
                        grant_id    <= winner;
                        grant_valid <= 1'b1;
                        last_owner  <= winner;
                    end else begin
                        state       <= ST_PARK;
                        GNT_N       <= ~PARK_MASK;
                        grant_id    <= PARK_ID;
                        grant_valid <= 1'b1;
                    end
                end

                ST_PARK: begin
                    idle_cnt <= '0;
                    started  <= 1'b0;
                    if (park_other) begin
                        state       <= ST_GAP;
                        GNT_N       <= '1;
                        grant_valid <= 1'b0;
                    end else if (req[PARK_ID]) begin
                        // Parked master keeps its grant; no gap needed.
                        state      <= ST_GRANT;
                        last_owner <= PARK_ID;
                    end
                end

                ST_GRANT: begin
                    if (revoke) begin
                        state       <= ST_GAP;
                        GNT_N       <= '1;
                        grant_valid <= 1'b0;
                        idle_cnt    <= '0;
                        started     <= 1'b0;
                    end else begin
                        started     <= started | ~FRAME_N;
                        idle_cnt    <= idle_cnt_nxt;
                        // Pulse while the counter sits at its limit; the
                        // grant is withdrawn at the following edge.
                        timeout_evt <= (idle_cnt_nxt == CNT_MAX);
                    end
                end

                default: begin
                    state       <= ST_GAP;
                    GNT_N       <= '1;
                    grant_valid <= 1'b0;
                    idle_cnt    <= '0;
                    started     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/pci_arbiter.md
PCI_ARBITER -- requirements
Module: pci_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of bus masters, range 2..8.
REQ-002 SHALL have parameter PARK, default 0: index of the master parked on the bus when no requests are pending.
REQ-003 SHALL have parameter TIMEOUT, default 16: number of idle-bus clocks a granted master may leave unused before its grant is revoked.
REQ-004 SHALL have port PCLK  input  1  bus clock; all logic uses its rising edge.
REQ-005 SHALL have port RST_N  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port REQ_N  input  N_REQ  per-master bus request, active low.
REQ-007 SHALL have port GNT_N  output  N_REQ  per-master bus grant, active low, registered.
REQ-008 SHALL have port FRAME_N  input  1  bus FRAME#, sampled only.
REQ-009 SHALL have port IRDY_N  input  1  bus IRDY#, sampled only.
REQ-010 SHALL have port grant_id  output  clog2(N_REQ)  index of the current grant holder, registered.
REQ-011 SHALL have port grant_valid  output  1  high while a grant is asserted, registered.
REQ-012 SHALL have port timeout_evt  output  1  one-cycle pulse when a grant is revoked by timeout.

Function
REQ-013 SHALL define bus idle as FRAME_N=1 and IRDY_N=1 at the same rising edge of PCLK.
REQ-014 SHALL assert at most one GNT_N bit in any cycle.
REQ-015 SHALL implement exactly three states: PARK, GRANT and GAP.
REQ-016 PARK SHALL drive GNT_N[PARK]=0 with grant_id=PARK and grant_valid=1.
REQ-017 GRANT SHALL drive GNT_N[owner]=0 with grant_id=owner and grant_valid=1.
REQ-018 GAP SHALL drive all GNT_N bits high with grant_valid=0 and SHALL last exactly one cycle.
REQ-019 GAP SHALL pick the winner by round-robin over the REQ_N sampled in that cycle, with highest priority at index last_owner+1 mod N_REQ.
REQ-020 GAP SHALL go to GRANT(winner), or to PARK if no request is pending.
REQ-021 In PARK, a request from any master other than PARK SHALL cause a transition to GAP.
REQ-022 In PARK, a request from master PARK alone SHALL cause a transition to GRANT(PARK) with no change on GNT_N and no GAP cycle.
REQ-023 GRANT SHALL set a "started" flag when FRAME_N=0 is sampled while granted; the flag SHALL clear on every grant change.
REQ-024 GRANT SHALL go to GAP when REQ_N[owner]=1.
REQ-025 GRANT SHALL go to GAP when started=1 and any other REQ_N bit is 0, giving one transaction per grant under contention.
REQ-026 GRANT SHALL go to GAP when the timeout counter reaches TIMEOUT; timeout_evt SHALL pulse for exactly that cycle.
REQ-027 The timeout counter SHALL be clog2(TIMEOUT+1) bits wide.
REQ-028 The timeout counter SHALL increment only in GRANT, with the bus idle and started=0, and SHALL saturate at TIMEOUT.
REQ-029 The timeout counter SHALL clear on any grant change and whenever the bus is busy.
REQ-030 The arbiter SHALL NOT wait for the bus to go idle before revoking a grant; the master already owning the bus completes its transaction unaffected.
REQ-031 When the owner deasserts REQ_N in the same cycle another master asserts it, the arbiter SHALL go to GAP and then grant the new requester.
REQ-032 last_owner SHALL update on entry to GRANT; a timed-out owner SHALL receive lowest priority at the next arbitration.

Reset
REQ-033 While RST_N=0, GNT_N SHALL be all ones, grant_valid=0, grant_id=0 and timeout_evt=0, asynchronously and without waiting for a PCLK edge.
REQ-034 While RST_N=0, the state SHALL be GAP, last_owner=N_REQ-1, the timeout counter 0 and started 0.
REQ-035 The first cycle after reset release SHALL therefore be a GAP cycle, with master 0 at highest priority.

Structure
REQ-036 Shared package pci_pkg SHALL hold the state encodings and PCI command constants for use by the arbiter and the test masters.
REQ-037 Sub-module pci_rr_pick SHALL hold the purely combinational rotate-priority picker.
REQ-038 pci_rr_pick inputs SHALL be the request vector and last_owner; its outputs SHALL be winner and any_req.

Verification (N_REQ=4, PARK=0, TIMEOUT=16)
REQ-039 No requests after reset -> GNT_N=1111 during reset and for 1 cycle after release, then GNT_N=1110 held.
REQ-040 From PARK, REQ_N=1011 -> GNT_N=1111 for 1 cycle, then GNT_N=1011 with grant_id=2.
REQ-041 From PARK, REQ_N=1110 -> GNT_N stays 1110 with no gap cycle, state GRANT.
REQ-042 All REQ_N=0 and each master runs one single-phase write per grant -> grant order 0,1,2,3,0, with a one-cycle all-high gap between grants.
REQ-043 Master 1 granted, FRAME_N never asserted -> timeout_evt pulses after 16 idle clocks, then GNT_N=1111 for 1 cycle, then the next requester is granted.
REQ-044 RST_N driven low mid-GRANT between clock edges -> GNT_N=1111 in the same time step; after release, behaviour matches REQ-039.
